enclave_cmd_issuer: RTL and testbench

- Host-side initiator for the FHE operation controller.
- Accepts operation descriptors (opcode, three base addresses, noise, tag) from the host through a valid/ready queue.
- Issues each descriptor to the controller as a one-cycle config_en pulse, then waits for the controller's done flag.
- Reports completion or timeout per tag; serialises operations so the controller never receives a config while an operation is in flight.

---
 rtl/enclave_cmd_issuer_if.sv | 45 ++++
 rtl/enclave_cmd_issuer.sv | 178 +++++++++++++++++
 tb/tb_enclave_cmd_issuer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/enclave_cmd_issuer_if.sv
// Host command queue, controller config and response bundle
// for the enclave command issuer.
interface enclave_cmd_issuer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int BIG_N      = 30,
    parameter int PTR_WIDTH  = 2,
    parameter int TAG_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_opcode;
    logic [ADDR_WIDTH-1:0] cmd_op1_base;
    logic [ADDR_WIDTH-1:0] cmd_op2_base;
    logic [ADDR_WIDTH-1:0] cmd_out_base;
    logic [BIG_N-1:0]      cmd_noise;
    logic [TAG_WIDTH-1:0]  cmd_tag;
    logic                  config_en;
    logic [1:0]            opcode;
    logic [ADDR_WIDTH-1:0] op1_base_addr;
    logic [ADDR_WIDTH-1:0] op2_base_addr;
    logic [ADDR_WIDTH-1:0] out_base_addr;
    logic [BIG_N-1:0]      noise;
    logic                  ctrl_done;
    logic                  rsp_valid;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic                  rsp_timeout;
    logic                  busy;
    logic [PTR_WIDTH:0]    fifo_count;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_op1_base, cmd_op2_base,
        input  cmd_out_base, cmd_noise, cmd_tag, ctrl_done,
        output cmd_ready, config_en, opcode, op1_base_addr,
        output op2_base_addr, out_base_addr, noise,
        output rsp_valid, rsp_tag, rsp_timeout, busy, fifo_count
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_op1_base, cmd_op2_base,
        output cmd_out_base, cmd_noise, cmd_tag, ctrl_done,
        input  cmd_ready, config_en, opcode, op1_base_addr,
        input  op2_base_addr, out_base_addr, noise,
        input  rsp_valid, rsp_tag, rsp_timeout, busy, fifo_count
    );
endinterface

// File: rtl/enclave_cmd_issuer.sv
// Queues host FHE op descriptors and issues them one at a time
// to the controller, retiring each on done or timeout.
module enclave_cmd_issuer #(
    parameter int ADDR_WIDTH = 10,
    parameter int BIG_N      = 30,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2,
    parameter int TAG_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input logic                 clk,
    input logic                 rst,
    enclave_cmd_issuer_if.slave bus
);
    typedef struct packed {
        logic [1:0]            opcode;
        logic [ADDR_WIDTH-1:0] op1;
        logic [ADDR_WIDTH-1:0] op2;
        logic [ADDR_WIDTH-1:0] out;
        logic [BIG_N-1:0]      noise;
        logic [TAG_WIDTH-1:0]  tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE, CONFIG, RUN, RETIRE
    } state_t;

    localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    cmd_t mem [DEPTH];
    cmd_t cmd_in;
    cmd_t head;

    state_t                state_q, state_d;
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic [7:0]            timer_q, timer_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [1:0]            opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0] op1_q, op1_d;
    logic [ADDR_WIDTH-1:0] op2_q, op2_d;
    logic [ADDR_WIDTH-1:0] out_q, out_d;
    logic [BIG_N-1:0]      noise_q, noise_d;
    logic                  config_en_q, config_en_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  cmd_ready;
    logic                  push;
    logic                  pop;

    assign cmd_ready = (count_q != FULL);
    assign push      = bus.cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = mem[rd_ptr_q];

    assign cmd_in = '{
        opcode: bus.cmd_opcode,
        op1:    bus.cmd_op1_base,
        op2:    bus.cmd_op2_base,
        out:    bus.cmd_out_base,
        noise:  bus.cmd_noise,
        tag:    bus.cmd_tag
    };

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        timer_d       = timer_q;
        tag_d         = tag_q;
        opcode_d      = opcode_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        out_d         = out_q;
        noise_d       = noise_q;
        config_en_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    opcode_d    = head.opcode;
                    op1_d       = head.op1;
                    op2_d       = head.op2;
                    out_d       = head.out;
                    noise_d     = head.noise;
                    tag_d       = head.tag;
                    config_en_d = 1'b1;
                    state_d     = CONFIG;
                end
            end
            CONFIG: begin
                // done may still be high from the last op; ignore it here
                timer_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (bus.ctrl_done) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RETIRE;
                end else if (timer_q == TMO_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RETIRE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            tag_q         <= '0;
            opcode_q      <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            out_q         <= '0;
            noise_q       <= '0;
            config_en_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            tag_q         <= tag_d;
            opcode_q      <= opcode_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            out_q         <= out_d;
            noise_q       <= noise_d;
            config_en_q   <= config_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.config_en     = config_en_q;
    assign bus.opcode        = opcode_q;
    assign bus.op1_base_addr = op1_q;
    assign bus.op2_base_addr = op2_q;
    assign bus.out_base_addr = out_q;
    assign bus.noise         = noise_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_tag       = tag_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.busy          = (state_q != IDLE) || (count_q != '0);
    assign bus.fifo_count    = count_q;
endmodule

// File: tb/tb_enclave_cmd_issuer.sv
// Directed bench: dut_a uses the default timeout, dut_b uses
// TIMEOUT=3 for the queue-full, timeout and reset scenarios.
module tb_enclave_cmd_issuer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cfg_t [$];
    int   rtag [$];
    int   rtmo [$];
    int   nrsp;

    enclave_cmd_issuer_if ifa ();
    enclave_cmd_issuer_if ifb ();

    enclave_cmd_issuer dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    enclave_cmd_issuer #(.TIMEOUT(3)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ifa.cmd_valid = 0; ifa.cmd_opcode = 0; ifa.cmd_tag = 0;
        ifa.cmd_op1_base = 0; ifa.cmd_op2_base = 0;
        ifa.cmd_out_base = 0; ifa.cmd_noise = 0; ifa.ctrl_done = 0;
        ifb.cmd_valid = 0; ifb.cmd_opcode = 0; ifb.cmd_tag = 0;
        ifb.cmd_op1_base = 0; ifb.cmd_op2_base = 0;
        ifb.cmd_out_base = 0; ifb.cmd_noise = 0; ifb.ctrl_done = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ifa.cmd_ready, 1);
        chk("rst_cfg", ifa.config_en, 0);
        chk("rst_cnt", ifb.fifo_count, 0);
        chk("rst_busy", ifb.busy, 0);
        chk("rst_rsp", ifa.rsp_valid, 0);
        chk("rst_opc", ifa.opcode, 0);
        tick();
        rst = 1'b0;

        // single command, done after four RUN cycles
        tick();
        ifa.cmd_valid = 1; ifa.cmd_opcode = 2; ifa.cmd_tag = 5;
        ifa.cmd_op1_base = 10'h010; ifa.cmd_op2_base = 10'h020;
        ifa.cmd_out_base = 10'h030; ifa.cmd_noise = 30'h1234;
        @(negedge clk);
        chk("t1_ready", ifa.cmd_ready, 1);
        tick();
        ifa.cmd_valid = 0;
        @(negedge clk);
        chk("t1_cnt1", ifa.fifo_count, 1);
        chk("t1_cfg_early", ifa.config_en, 0);
        tick();
        @(negedge clk);
        chk("t1_cfg", ifa.config_en, 1);
        chk("t1_opc", ifa.opcode, 2);
        chk("t1_op1", ifa.op1_base_addr, 10'h010);
        chk("t1_op2", ifa.op2_base_addr, 10'h020);
        chk("t1_out", ifa.out_base_addr, 10'h030);
        chk("t1_noise", ifa.noise, 30'h1234);
        chk("t1_busy", ifa.busy, 1);
        tick();
        @(negedge clk);
        chk("t1_cfg_off", ifa.config_en, 0);
        repeat (2) tick();
        tick();
        ifa.ctrl_done = 1;
        @(negedge clk);
        chk("t1_rsp_early", ifa.rsp_valid, 0);
        tick();
        ifa.ctrl_done = 0;
        @(negedge clk);
        chk("t1_rsp", ifa.rsp_valid, 1);
        chk("t1_tag", ifa.rsp_tag, 5);
        chk("t1_tmo", ifa.rsp_timeout, 0);
        chk("t1_hold", ifa.opcode, 2);
        tick();
        @(negedge clk);
        chk("t1_rsp_off", ifa.rsp_valid, 0);
        chk("t1_idle", ifa.busy, 0);

        // stale done held high through CONFIG
        ifa.ctrl_done = 1;
        tick();
        ifa.cmd_valid = 1; ifa.cmd_opcode = 1; ifa.cmd_tag = 7;
        tick();
        ifa.cmd_valid = 0;
        tick();
        @(negedge clk);
        chk("t3_cfg", ifa.config_en, 1);
        chk("t3_opc", ifa.opcode, 1);
        tick();
        @(negedge clk);
        chk("t3_rsp_early", ifa.rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("t3_rsp", ifa.rsp_valid, 1);
        chk("t3_tag", ifa.rsp_tag, 7);
        chk("t3_tmo", ifa.rsp_timeout, 0);
        ifa.ctrl_done = 0;

        // five back-to-back pushes, all time out; full-queue push rejected
        for (int c = 0; c < 36; c++) begin
            tick();
            if (c < 5) begin
                ifb.cmd_valid = 1; ifb.cmd_tag = 4'(c);
            end else if (c < 8) begin
                ifb.cmd_valid = 1; ifb.cmd_tag = 9;
            end else begin
                ifb.cmd_valid = 0;
            end
            @(negedge clk);
            if (ifb.config_en) cfg_t.push_back(c);
            if (ifb.rsp_valid) begin
                rtag.push_back(int'(ifb.rsp_tag));
                rtmo.push_back(int'(ifb.rsp_timeout));
            end
            if (c == 4) chk("t2_ready_c4", ifb.cmd_ready, 1);
            if (c == 5) begin
                chk("t2_ready_full", ifb.cmd_ready, 0);
                chk("t2_cnt_full", ifb.fifo_count, 4);
            end
            if (c == 7) chk("t2_ready_pop", ifb.cmd_ready, 0);
            if (c == 8) chk("t2_cnt_pop", ifb.fifo_count, 3);
        end
        chk("t2_ncfg", cfg_t.size(), 5);
        chk("t2_nrsp", rtag.size(), 5);
        for (int i = 0; i < cfg_t.size(); i++)
            chk("t2_cfg_time", cfg_t[i], 2 + 6 * i);
        for (int i = 0; i < rtag.size(); i++) begin
            chk("t2_tag", rtag[i], i);
            chk("t2_tmo", rtmo[i], 1);
        end
        chk("t2_idle", ifb.busy, 0);

        // done on third RUN cycle beats the timeout
        tick();
        ifb.cmd_valid = 1; ifb.cmd_tag = 3;
        tick();
        ifb.cmd_valid = 0;
        tick();
        @(negedge clk);
        chk("t4a_cfg", ifb.config_en, 1);
        repeat (2) tick();
        tick();
        ifb.ctrl_done = 1;
        @(negedge clk);
        chk("t4a_rsp_early", ifb.rsp_valid, 0);
        tick();
        ifb.ctrl_done = 0;
        @(negedge clk);
        chk("t4a_rsp", ifb.rsp_valid, 1);
        chk("t4a_tag", ifb.rsp_tag, 3);
        chk("t4a_tmo", ifb.rsp_timeout, 0);

        // done on fourth cycle arrives after the timeout
        tick();
        ifb.cmd_valid = 1; ifb.cmd_tag = 4;
        tick();
        ifb.cmd_valid = 0;
        repeat (3) tick();
        tick();
        @(negedge clk);
        chk("t4b_rsp_early", ifb.rsp_valid, 0);
        tick();
        ifb.ctrl_done = 1;
        @(negedge clk);
        chk("t4b_rsp", ifb.rsp_valid, 1);
        chk("t4b_tag", ifb.rsp_tag, 4);
        chk("t4b_tmo", ifb.rsp_timeout, 1);
        tick();
        ifb.ctrl_done = 0;
        @(negedge clk);
        chk("t4b_rsp_off", ifb.rsp_valid, 0);

        // asynchronous reset while RUN with two queued
        tick();
        ifb.cmd_valid = 1; ifb.cmd_tag = 10; ifb.cmd_opcode = 3;
        ifb.cmd_op1_base = 10'h3ff; ifb.cmd_noise = 30'h2aaaaaaa;
        tick();
        ifb.cmd_tag = 11;
        tick();
        ifb.cmd_tag = 12;
        tick();
        ifb.cmd_valid = 0;
        @(negedge clk);
        chk("t5_cnt", ifb.fifo_count, 2);
        chk("t5_opc", ifb.opcode, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_r_opc", ifb.opcode, 0);
        chk("t5_r_op1", ifb.op1_base_addr, 0);
        chk("t5_r_noise", ifb.noise, 0);
        chk("t5_r_tag", ifb.rsp_tag, 0);
        chk("t5_r_cnt", ifb.fifo_count, 0);
        chk("t5_r_busy", ifb.busy, 0);
        chk("t5_r_ready", ifb.cmd_ready, 1);
        chk("t5_r_rsp", ifb.rsp_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            if (ifb.rsp_valid || ifb.config_en) nrsp++;
        end
        chk("t5_quiet", nrsp, 0);
        ifb.ctrl_done = 1;
        tick();
        ifb.cmd_valid = 1; ifb.cmd_tag = 6; ifb.cmd_opcode = 1;
        tick();
        ifb.cmd_valid = 0;
        tick();
        @(negedge clk);
        chk("t5_cfg", ifb.config_en, 1);
        chk("t5_new_opc", ifb.opcode, 1);
        tick();
        tick();
        @(negedge clk);
        chk("t5_rsp", ifb.rsp_valid, 1);
        chk("t5_tag", ifb.rsp_tag, 6);
        chk("t5_tmo", ifb.rsp_timeout, 0);
        ifb.ctrl_done = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
